// File: rtl/rv32i_axi_mem_ctrl_if.sv
// AXI4-Lite master bus between the RV32I external-access sequencer and the SoC interconnect.
// Every channel uses strict valid/ready: a transfer happens on the rising edge where both are high; valid, once raised, holds with stable payload until that edge.
interface rv32i_axi_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic              m_axi_awvalid;
  logic              m_axi_awready;
  logic [31:0]       m_axi_wdata;
  logic [3:0]        m_axi_wstrb;
  logic              m_axi_wvalid;
  logic              m_axi_wready;
  logic [1:0]        m_axi_bresp;
  logic              m_axi_bvalid;
  logic              m_axi_bready;
  logic [ADDR_W-1:0] m_axi_araddr;
  logic              m_axi_arvalid;
  logic              m_axi_arready;
  logic [31:0]       m_axi_rdata;
  logic [1:0]        m_axi_rresp;
  logic              m_axi_rvalid;
  logic              m_axi_rready;

  modport master (
    output m_axi_awaddr, m_axi_awvalid, input m_axi_awready,
    output m_axi_wdata, m_axi_wstrb, m_axi_wvalid, input m_axi_wready,
    input m_axi_bresp, m_axi_bvalid, output m_axi_bready,
    output m_axi_araddr, m_axi_arvalid, input m_axi_arready,
    input m_axi_rdata, m_axi_rresp, m_axi_rvalid, output m_axi_rready
  );

  modport slave (
    input m_axi_awaddr, m_axi_awvalid, output m_axi_awready,
    input m_axi_wdata, m_axi_wstrb, m_axi_wvalid, output m_axi_wready,
    output m_axi_bresp, m_axi_bvalid, input m_axi_bready,
    input m_axi_araddr, m_axi_arvalid, output m_axi_arready,
    output m_axi_rdata, m_axi_rresp, m_axi_rvalid, input m_axi_rready
  );
endinterface

// File: rtl/rv32i_axi_mem_ctrl.sv
// Turns one stalled MA-stage external access into a single AXI4-Lite transaction,
// applying RV32I lane/extension rules and returning load data on the write-back side port.
module rv32i_axi_mem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 1024,
  parameter int TO_CNT_W    = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_init_i,
  input  logic        core_mem_we_i,
  input  logic [2:0]  core_funct3_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_data_w_i,
  input  logic [4:0]  core_addr_d_i,
  output logic        core_stall_o,
  output logic        core_reg_we_o,
  output logic [4:0]  core_addr_d_o,
  output logic [31:0] core_data_d_o,
  output logic        err_o,
  input  logic        err_clr_i,
  rv32i_axi_mem_ctrl_if.master m_axi,
  output logic [2:0]  dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WADDR = 3'd1,
    S_WRESP = 3'd2,
    S_RADDR = 3'd3,
    S_RDATA = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [TO_CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic [1:0]          off_q, off_d;
  logic [2:0]          funct3_q, funct3_d;
  logic                we_q, we_d;
  logic [4:0]          rd_q, rd_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d, araddr_q, araddr_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          wstrb_q, wstrb_d;

  logic                err_set, timeout, misalign, busy;
  logic [1:0]          req_size;

  // Access size: 0 = byte, 1 = halfword, 2 = word (undefined funct3 falls back to word).
  function automatic logic [1:0] acc_size(input logic we, input logic [2:0] f3);
    if (f3 == 3'b000 || (!we && f3 == 3'b100)) return 2'd0;
    if (f3 == 3'b001 || (!we && f3 == 3'b101)) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic [31:0] sh;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'b0, sh[7:0]};
      3'b101:  return {16'b0, sh[15:0]};
      default: return rdata;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      to_cnt_q  <= '0;
      off_q     <= '0;
      funct3_q  <= '0;
      we_q      <= 1'b0;
      rd_q      <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      awaddr_q  <= '0;
      awvalid_q <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      wvalid_q  <= 1'b0;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      to_cnt_q  <= to_cnt_d;
      off_q     <= off_d;
      funct3_q  <= funct3_d;
      we_q      <= we_d;
      rd_q      <= rd_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      awaddr_q  <= awaddr_d;
      awvalid_q <= awvalid_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      wvalid_q  <= wvalid_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    off_d     = off_q;
    funct3_d  = funct3_q;
    we_d      = we_q;
    rd_d      = rd_q;
    rdata_d   = rdata_q;
    awaddr_d  = awaddr_q;
    awvalid_d = awvalid_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    wvalid_d  = wvalid_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    err_set   = 1'b0;
    timeout   = (to_cnt_q == TO_CNT_W'(TIMEOUT_CYC - 1));
    req_size  = acc_size(core_mem_we_i, core_funct3_i);
    misalign  = (req_size == 2'd1 && core_addr_i[0]) ||
                (req_size == 2'd2 && core_addr_i[1:0] != 2'b00);
    busy      = (state_q != S_IDLE) && (state_q != S_DONE);

    case (state_q)
      S_IDLE: begin
        if (core_init_i) begin
          off_d    = core_addr_i[1:0];
          funct3_d = core_funct3_i;
          we_d     = core_mem_we_i;
          rd_d     = core_addr_d_i;
          rdata_d  = '0;
          if (misalign) begin
            state_d = S_DONE;
            err_set = 1'b1;
          end else if (core_mem_we_i) begin
            state_d   = S_WADDR;
            awaddr_d  = ADDR_W'({core_addr_i[31:2], 2'b00});
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            case (req_size)
              2'd0: begin
                wdata_d = {4{core_data_w_i[7:0]}};
                wstrb_d = 4'b0001 << core_addr_i[1:0];
              end
              2'd1: begin
                wdata_d = {2{core_data_w_i[15:0]}};
                wstrb_d = 4'b0011 << core_addr_i[1:0];
              end
              default: begin
                wdata_d = core_data_w_i;
                wstrb_d = 4'b1111;
              end
            endcase
          end else begin
            state_d   = S_RADDR;
            araddr_d  = ADDR_W'({core_addr_i[31:2], 2'b00});
            arvalid_d = 1'b1;
          end
        end
      end
      S_WADDR: begin
        // Address and data channels retire independently; leave once neither is pending.
        if (awvalid_q && m_axi.m_axi_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi.m_axi_wready)   wvalid_d  = 1'b0;
        if ((!awvalid_q || m_axi.m_axi_awready) && (!wvalid_q || m_axi.m_axi_wready)) begin
          state_d = S_WRESP;
        end else if (timeout) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b0;
          err_set   = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_WRESP: begin
        if (m_axi.m_axi_bvalid) begin
          state_d = S_DONE;
          err_set = (m_axi.m_axi_bresp != 2'b00);
        end else if (timeout) begin
          err_set = 1'b1;
          state_d = S_DONE;
        end
      end
      S_RADDR: begin
        if (m_axi.m_axi_arready) begin
          arvalid_d = 1'b0;
          state_d   = S_RDATA;
        end else if (timeout) begin
          arvalid_d = 1'b0;
          err_set   = 1'b1;
          state_d   = S_DONE;
        end
      end
      S_RDATA: begin
        if (m_axi.m_axi_rvalid) begin
          state_d = S_DONE;
          if (m_axi.m_axi_rresp != 2'b00) begin
            err_set = 1'b1;
            rdata_d = '0;
          end else begin
            rdata_d = load_ext(funct3_q, off_q, m_axi.m_axi_rdata);
          end
        end else if (timeout) begin
          err_set = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) to_cnt_d = '0;
    else if (busy)          to_cnt_d = to_cnt_q + 1'b1;

    // A new error outranks a clear arriving in the same cycle.
    err_d = err_set ? 1'b1 : (err_clr_i ? 1'b0 : err_q);
  end

  assign core_stall_o  = ((state_q != S_IDLE) && (state_q != S_DONE)) ||
                         ((state_q == S_IDLE) && core_init_i);
  assign core_reg_we_o = (state_q == S_DONE) && !we_q && (rd_q != 5'd0);
  assign core_addr_d_o = rd_q;
  assign core_data_d_o = rdata_q;
  assign err_o         = err_q;
  assign dbg_state_o   = state_q;

  assign m_axi.m_axi_awaddr  = awaddr_q;
  assign m_axi.m_axi_awvalid = awvalid_q;
  assign m_axi.m_axi_wdata   = wdata_q;
  assign m_axi.m_axi_wstrb   = wstrb_q;
  assign m_axi.m_axi_wvalid  = wvalid_q;
  assign m_axi.m_axi_bready  = (state_q == S_WRESP);
  assign m_axi.m_axi_araddr  = araddr_q;
  assign m_axi.m_axi_arvalid = arvalid_q;
  assign m_axi.m_axi_rready  = (state_q == S_RDATA);

endmodule

// File: tb/tb_rv32i_axi_mem_ctrl.sv
// Directed bench for rv32i_axi_mem_ctrl: a configurable-wait AXI4-Lite slave plus a linear
// sequence of hand-computed load/store/error/timeout/reset vectors.
module tb_rv32i_axi_mem_ctrl;
  localparam logic [2:0] S_IDLE = 3'd0, S_RDATA = 3'd4, S_DONE = 3'd5;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_init_i, core_mem_we_i, err_clr_i;
  logic [2:0]  core_funct3_i;
  logic [31:0] core_addr_i, core_data_w_i;
  logic [4:0]  core_addr_d_i;
  logic        core_stall_o, core_reg_we_o, err_o;
  logic [4:0]  core_addr_d_o;
  logic [31:0] core_data_d_o;
  logic [2:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;

  // Slave configuration, written only by the stimulus block.
  int          aw_wait = 0, w_wait = 0, b_wait = 0, ar_wait = 0, r_wait = 0;
  logic [31:0] r_data = '0;
  logic [1:0]  r_resp = 2'b00, b_resp = 2'b00;

  // Slave observations, written only by the slave process.
  int          cyc = 0, done_cnt = 0, valid_cnt = 0, arv_cnt = 0;
  int          aw_hs_cyc = 0, w_hs_cyc = 0;
  logic [31:0] cap_awaddr = '0, cap_wdata = '0;
  logic [3:0]  cap_wstrb = '0;

  always #5 clk = ~clk;

  rv32i_axi_mem_ctrl_if #(.ADDR_W(32)) axi ();

  rv32i_axi_mem_ctrl #(.ADDR_W(32), .TIMEOUT_CYC(1024), .TO_CNT_W(11)) dut (
    .clk           (clk),
    .rst           (rst),
    .core_init_i   (core_init_i),
    .core_mem_we_i (core_mem_we_i),
    .core_funct3_i (core_funct3_i),
    .core_addr_i   (core_addr_i),
    .core_data_w_i (core_data_w_i),
    .core_addr_d_i (core_addr_d_i),
    .core_stall_o  (core_stall_o),
    .core_reg_we_o (core_reg_we_o),
    .core_addr_d_o (core_addr_d_o),
    .core_data_d_o (core_data_d_o),
    .err_o         (err_o),
    .err_clr_i     (err_clr_i),
    .m_axi         (axi),
    .dbg_state_o   (dbg_state)
  );

  // Slave: evaluates valids on each falling edge and raises ready after the configured wait.
  initial begin
    int aw_c, w_c, b_c, ar_c, r_c;
    aw_c = 0; w_c = 0; b_c = 0; ar_c = 0; r_c = 0;
    axi.m_axi_awready = 1'b0; axi.m_axi_wready = 1'b0;
    axi.m_axi_bvalid = 1'b0;  axi.m_axi_bresp = 2'b00;
    axi.m_axi_arready = 1'b0; axi.m_axi_rvalid = 1'b0;
    axi.m_axi_rdata = '0;     axi.m_axi_rresp = 2'b00;
    forever begin
      @(negedge clk);
      cyc++;
      if (dbg_state == S_DONE) done_cnt++;
      if (axi.m_axi_awvalid || axi.m_axi_wvalid || axi.m_axi_arvalid) valid_cnt++;
      if (axi.m_axi_arvalid) arv_cnt++;
      if (axi.m_axi_awvalid) begin
        axi.m_axi_awready = (aw_c >= aw_wait);
        if (aw_c < aw_wait) aw_c++;
        if (axi.m_axi_awready) begin cap_awaddr = axi.m_axi_awaddr; aw_hs_cyc = cyc; end
      end else begin
        axi.m_axi_awready = 1'b0; aw_c = 0;
      end
      if (axi.m_axi_wvalid) begin
        axi.m_axi_wready = (w_c >= w_wait);
        if (w_c < w_wait) w_c++;
        if (axi.m_axi_wready) begin
          cap_wdata = axi.m_axi_wdata; cap_wstrb = axi.m_axi_wstrb; w_hs_cyc = cyc;
        end
      end else begin
        axi.m_axi_wready = 1'b0; w_c = 0;
      end
      if (axi.m_axi_bready) begin
        axi.m_axi_bvalid = (b_c >= b_wait);
        axi.m_axi_bresp  = b_resp;
        if (b_c < b_wait) b_c++;
      end else begin
        axi.m_axi_bvalid = 1'b0; b_c = 0;
      end
      if (axi.m_axi_arvalid) begin
        axi.m_axi_arready = (ar_c >= ar_wait);
        if (ar_c < ar_wait) ar_c++;
      end else begin
        axi.m_axi_arready = 1'b0; ar_c = 0;
      end
      if (axi.m_axi_rready) begin
        axi.m_axi_rvalid = (r_c >= r_wait);
        axi.m_axi_rdata  = r_data;
        axi.m_axi_rresp  = r_resp;
        if (r_c < r_wait) r_c++;
      end else begin
        axi.m_axi_rvalid = 1'b0; r_c = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Starts an access on the current falling edge and returns at the falling edge inside DONE.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] data, input logic [4:0] rd, output int cycles);
    core_init_i = 1'b1; core_mem_we_i = we; core_funct3_i = f3;
    core_addr_i = addr; core_data_w_i = data; core_addr_d_i = rd;
    cycles = 0;
    while (dbg_state !== S_DONE && cycles < 3000) begin
      @(negedge clk);
      cycles++;
    end
    core_init_i = 1'b0;
    chk("done_reached", {29'b0, dbg_state}, {29'b0, S_DONE});
  endtask

  initial begin
    int n, d0, v0, a0;
    rst = 1'b1; core_init_i = 1'b0; core_mem_we_i = 1'b0; core_funct3_i = 3'b000;
    core_addr_i = '0; core_data_w_i = '0; core_addr_d_i = '0; err_clr_i = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_state", {29'b0, dbg_state}, {29'b0, S_IDLE});
    chk("rst_awvalid", axi.m_axi_awvalid, 0);
    chk("rst_wvalid", axi.m_axi_wvalid, 0);
    chk("rst_arvalid", axi.m_axi_arvalid, 0);
    chk("rst_ready", {axi.m_axi_bready, axi.m_axi_rready}, 0);
    chk("rst_awaddr", axi.m_axi_awaddr, 0);
    chk("rst_wdata", axi.m_axi_wdata, 0);
    chk("rst_wstrb", axi.m_axi_wstrb, 0);
    chk("rst_araddr", axi.m_axi_araddr, 0);
    chk("rst_core", {core_stall_o, core_reg_we_o, err_o, core_addr_d_o}, 0);
    chk("rst_data", core_data_d_o, 0);
    rst = 1'b0;
    @(negedge clk);

    // LW @0x1000_0004, zero-wait slave: write-back 3 cycles after init.
    r_data = 32'hDEADBEEF; r_resp = 2'b00;
    core_init_i = 1'b1; core_mem_we_i = 1'b0; core_funct3_i = 3'b010;
    core_addr_i = 32'h1000_0004; core_addr_d_i = 5'd5;
    #1;
    chk("lw_stall_c0", core_stall_o, 1);
    @(negedge clk);
    chk("lw_stall_c1", core_stall_o, 1);
    chk("lw_arvalid_c1", axi.m_axi_arvalid, 1);
    chk("lw_araddr", axi.m_axi_araddr, 32'h1000_0004);
    @(negedge clk);
    chk("lw_stall_c2", core_stall_o, 1);
    chk("lw_state_c2", {29'b0, dbg_state}, {29'b0, S_RDATA});
    @(negedge clk);
    chk("lw_state_c3", {29'b0, dbg_state}, {29'b0, S_DONE});
    chk("lw_reg_we_c3", core_reg_we_o, 1);
    chk("lw_data", core_data_d_o, 32'hDEADBEEF);
    chk("lw_rd", core_addr_d_o, 5);
    chk("lw_stall_c3", core_stall_o, 0);
    core_init_i = 1'b0;
    @(negedge clk);
    chk("lw_reg_we_c4", core_reg_we_o, 0);

    // Byte/half lane selection and extension.
    r_data = 32'h80FF_0000;
    run_access(1'b0, 3'b000, 32'h1000_0003, 32'h0, 5'd6, n);
    chk("lb_cycles", n, 3);
    chk("lb_data", core_data_d_o, 32'hFFFF_FF80);
    chk("lb_reg_we", core_reg_we_o, 1);
    @(negedge clk);
    run_access(1'b0, 3'b100, 32'h1000_0003, 32'h0, 5'd6, n);
    chk("lbu_data", core_data_d_o, 32'h0000_0080);
    @(negedge clk);
    run_access(1'b0, 3'b101, 32'h1000_0002, 32'h0, 5'd6, n);
    chk("lhu_data", core_data_d_o, 32'h0000_80FF);
    @(negedge clk);
    run_access(1'b0, 3'b001, 32'h1000_0002, 32'h0, 5'd6, n);
    chk("lh_data", core_data_d_o, 32'hFFFF_80FF);
    @(negedge clk);

    // SH with wready 3 cycles after awready.
    aw_wait = 0; w_wait = 3; b_wait = 0; b_resp = 2'b00;
    d0 = done_cnt;
    run_access(1'b1, 3'b001, 32'h2000_0002, 32'h0000_1234, 5'd0, n);
    chk("sh_cycles", n, 6);
    chk("sh_reg_we", core_reg_we_o, 0);
    chk("sh_awaddr", cap_awaddr, 32'h2000_0000);
    chk("sh_wstrb", cap_wstrb, 4'b1100);
    chk("sh_wdata", cap_wdata, 32'h1234_1234);
    chk("sh_aw_first", w_hs_cyc - aw_hs_cyc, 3);
    chk("sh_err", err_o, 0);
    @(negedge clk);
    @(negedge clk);
    chk("sh_single_done", done_cnt - d0, 1);

    // SB at lane 1.
    w_wait = 0;
    run_access(1'b1, 3'b000, 32'h2000_0001, 32'h0000_00AB, 5'd0, n);
    chk("sb_cycles", n, 3);
    chk("sb_wstrb", cap_wstrb, 4'b0010);
    chk("sb_wdata", cap_wdata, 32'hABAB_ABAB);
    @(negedge clk);

    // Misaligned SW: no bus activity, error, stall released after one cycle.
    v0 = valid_cnt;
    run_access(1'b1, 3'b010, 32'h2000_0001, 32'h1111_2222, 5'd0, n);
    chk("sw_mis_cycles", n, 1);
    chk("sw_mis_stall", core_stall_o, 0);
    chk("sw_mis_err", err_o, 1);
    chk("sw_mis_reg_we", core_reg_we_o, 0);
    @(negedge clk);
    @(negedge clk);
    chk("sw_mis_no_valid", valid_cnt - v0, 0);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;
    chk("err_clr", err_o, 0);

    // Misaligned LH returns 0 with a write-back pulse.
    run_access(1'b0, 3'b001, 32'h1000_0001, 32'h0, 5'd3, n);
    chk("lh_mis_cycles", n, 1);
    chk("lh_mis_reg_we", core_reg_we_o, 1);
    chk("lh_mis_data", core_data_d_o, 0);
    chk("lh_mis_err", err_o, 1);
    err_clr_i = 1'b1;
    @(negedge clk);
    err_clr_i = 1'b0;

    // arready stuck low: arvalid held for 1024 cycles, then abort.
    ar_wait = 100000; r_data = 32'h5555_AAAA;
    a0 = arv_cnt;
    run_access(1'b0, 3'b010, 32'h1000_0010, 32'h0, 5'd7, n);
    chk("to_cycles", n, 1025);
    chk("to_arvalid", axi.m_axi_arvalid, 0);
    chk("to_err", err_o, 1);
    chk("to_reg_we", core_reg_we_o, 1);
    chk("to_data", core_data_d_o, 0);
    chk("to_rd", core_addr_d_o, 7);
    @(negedge clk);
    @(negedge clk);
    chk("to_arvalid_cycles", arv_cnt - a0, 1024);
    ar_wait = 0;

    // Reset while waiting in RDATA.
    r_wait = 100000;
    core_init_i = 1'b1; core_mem_we_i = 1'b0; core_funct3_i = 3'b010;
    core_addr_i = 32'h1000_0020; core_addr_d_i = 5'd9;
    n = 0;
    while (dbg_state !== S_RDATA && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_rst_in_rdata", {29'b0, dbg_state}, {29'b0, S_RDATA});
    chk("mid_rst_rready_before", axi.m_axi_rready, 1);
    #2;
    rst = 1'b1; core_init_i = 1'b0;
    #1;
    chk("mid_rst_state", {29'b0, dbg_state}, {29'b0, S_IDLE});
    chk("mid_rst_valids", {axi.m_axi_awvalid, axi.m_axi_wvalid, axi.m_axi_arvalid}, 0);
    chk("mid_rst_rready", axi.m_axi_rready, 0);
    chk("mid_rst_core", {core_stall_o, core_reg_we_o, err_o, core_addr_d_o}, 0);
    chk("mid_rst_data", core_data_d_o, 0);
    d0 = done_cnt;
    @(negedge clk);
    r_wait = 0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_no_done", done_cnt - d0, 0);

    // Load to x0 with SLVERR: error set, no write-back.
    r_resp = 2'b10; r_data = 32'h1234_5678;
    run_access(1'b0, 3'b010, 32'h1000_0008, 32'h0, 5'd0, n);
    chk("slverr_cycles", n, 3);
    chk("slverr_reg_we", core_reg_we_o, 0);
    chk("slverr_err", err_o, 1);
    chk("slverr_data", core_data_d_o, 0);
    @(negedge clk);
    chk("slverr_err_sticky", err_o, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
